uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one byte-wide UART transmitter among N requesters with round-robin arbitration and packet locking. Each requester presents bytes over a valid/ack handshake. The arbiter pulses the transmitter's send input, then tracks its busy flag until the byte completes. A requester marks its final byte with `last`, which holds the grant for the whole multi-byte packet so packets from different requesters never interleave on the serial line.

## Interface
- `N`, 4: number of requesters, range 2..8.
- `LOCK_TIMEOUT`, 1024: idle cycles a locked owner may withhold its next byte before the lock is forcibly released; 0 disables the timeout.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `halt`  in  1  when high, no new byte is issued; an in-flight byte completes.
- `req_valid`  in  N  requester i has a byte on `req_data[8i+7:8i]`.
- `req_last`  in  N  the presented byte ends requester i's packet.
- `req_data`  in  8N  byte per requester, packed.
- `req_ack`  out  N  one-cycle pulse when requester i's byte is accepted.
- `grant`  out  N  one-hot current owner; 0 when no owner.
- `locked`  out  1  an owner holds the packet lock.
- `timeout_err`  out  1  one-cycle pulse when a lock is force-released.
- `tx_send`  out  1  one-cycle send strobe to the transmitter.
- `tx_data`  out  8  byte to transmit; stable from `tx_send` until return to IDLE.
- `tx_busy`  in  1  transmitter busy flag; registered, rises the cycle after `tx_send`.

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer `ptr` = 0; lock cleared; timeout counter 0.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE, unlocked:
  - If `halt` = 0 and any `req_valid` bit is set, pick the first set bit scanning from `ptr` upward, wrapping modulo N.
  - Register the winner's byte into `tx_data`, set the one-hot `grant`, record the `last` bit, set `locked`, and go to ISSUE.
- IDLE, locked:
  - Only the owner is considered; other requesters wait.
  - If the owner's `req_valid` = 1 and `halt` = 0, capture its byte and go to ISSUE.
  - Otherwise increment the timeout counter; the counter is frozen while `halt` = 1.
  - When the counter reaches `LOCK_TIMEOUT` (and `LOCK_TIMEOUT` ≠ 0): clear the lock, set `grant` = 0, set `ptr` = owner+1 mod N, and pulse `timeout_err`.
  - The counter clears whenever a byte is issued.
- ISSUE (exactly one cycle): `tx_send` = 1, `req_ack[owner]` = 1, then go to WAIT_START. Requester lines are ignored from ISSUE until IDLE.
- WAIT_START: wait for `tx_busy` = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for `tx_busy` = 0, then go to IDLE.
  - If the recorded `last` = 1: clear `locked`, set `grant` = 0, set `ptr` = owner+1 mod N.
  - Otherwise the lock is retained.
- A single-byte packet (`last` = 1 on the first byte) still passes through the lock for that byte.
- `halt` is sampled only in IDLE; it never aborts ISSUE, WAIT_START or WAIT_DONE.
- Asynchronous reset mid-transfer returns the block to IDLE immediately with all outputs 0. The transmitter is reset by its own reset and is not cleaned up by this block.

## Timing
- `req_valid` sampled high in IDLE at edge t: `tx_send`, `req_ack` and valid `tx_data` are high/valid in the cycle after t.
- A requester must update `req_data`/`req_valid`/`req_last` no earlier than the edge that ends its `req_ack` cycle.
- `tx_busy` is seen low at edge k in WAIT_DONE: IDLE in cycle k+1; the earliest next `tx_send` is in cycle k+2.
- Minimum gap between consecutive `tx_send` strobes = transmitter frame time + 2 cycles.
- `timeout_err` is asserted in the cycle after the counter reaches `LOCK_TIMEOUT`; `grant` and `locked` drop in that same cycle.

## Test plan
- N=4, only requester 2 valid with byte 0x5A, `last` = 1:
  - one `tx_send` with `tx_data` = 0x5A, `req_ack` = 4'b0100;
  - after `tx_busy` falls: `grant` = 0, `locked` = 0, `ptr` = 3.
- Requesters 0 and 3 both valid, single-byte packets, `ptr` = 0:
  - order is 0 then 3;
  - with all four continuously valid, the grant sequence is 0,1,2,3,0.
- Requester 1 sends a 3-byte packet 0x11, 0x22, 0x33 (`last` on 0x33) while requester 0 is continuously valid:
  - `tx_data` sequence is 0x11, 0x22, 0x33 before any requester-0 byte;
  - `locked` stays 1 throughout the packet.
- `LOCK_TIMEOUT` = 8; requester 1 sends byte 0x44 without `last`, then drops valid:
  - `timeout_err` pulses 8 cycles after IDLE entry;
  - the next grant goes to the next valid requester from index 2.
- `halt` = 1 asserted during WAIT_DONE with requests pending:
  - the current byte completes;
  - no `tx_send` while `halt` = 1; issue resumes 1 cycle after `halt` falls.
- `rst_n` pulsed low during WAIT_DONE:
  - outputs go 0 asynchronously;
  - after release, requester 0 wins arbitration first (`ptr` = 0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmitter among N requesters.
// Round-robin arbitration with packet locking: once a requester wins, it keeps
// the grant until it sends a byte marked 'last' or stalls for LOCK_TIMEOUT
// idle cycles.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   halt              blocks new issues while high (sampled only in IDLE)
//   req_valid[N]      requester i presents a byte
//   req_last[N]       presented byte ends requester i's packet
//   req_data[8N]      packed bytes, requester i on [8i+7:8i]
//   req_ack[N]        one-cycle accept pulse to the owner
//   grant[N]          one-hot current owner, 0 when none
//   locked            an owner holds the packet lock
//   timeout_err       one-cycle pulse when the lock is force-released
//   tx_send           one-cycle send strobe to the transmitter
//   tx_data[8]        byte to transmit
//   tx_busy           transmitter busy flag
module uart_tx_arbiter #(
  parameter int unsigned N            = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           halt,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   grant,
  output logic           locked,
  output logic           timeout_err,
  output logic           tx_send,
  output logic [7:0]     tx_data,
  input  logic           tx_busy
);

  localparam int unsigned PW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  // Release fires on the edge where the counter would step to LOCK_TIMEOUT.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ISSUE      = 2'd1;
  localparam logic [1:0] WAIT_START = 2'd2;
  localparam logic [1:0] WAIT_DONE  = 2'd3;

  logic [1:0]       state, state_d;
  logic [PW-1:0]    ptr, ptr_d;
  logic [PW-1:0]    owner, owner_d;
  logic             last_q, last_d;
  logic             locked_d;
  logic [CNT_W-1:0] tmo_cnt, cnt_d;
  logic [N-1:0]     grant_d;
  logic [7:0]       tx_data_d;
  logic             tx_send_d;
  logic [N-1:0]     req_ack_d;
  logic             timeout_err_d;

  logic             found;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    sel;
  logic             take;

  // (base + inc) mod N for base < N, inc < N
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned inc);
    int unsigned s;
    s = 32'(base) + inc;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (PW'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Round-robin scan: first valid requester at or above ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = wrap_add(ptr, k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    owner_d       = owner;
    last_d        = last_q;
    locked_d      = locked;
    cnt_d         = tmo_cnt;
    grant_d       = grant;
    tx_data_d     = tx_data;
    tx_send_d     = 1'b0;
    req_ack_d     = '0;
    timeout_err_d = 1'b0;
    // While locked only the owner is eligible.
    sel  = locked ? owner : winner;
    take = !halt && (locked ? req_valid[owner] : found);

    case (state)
      IDLE: begin
        if (take) begin
          state_d   = ISSUE;
          owner_d   = sel;
          grant_d   = onehot(sel);
          locked_d  = 1'b1;
          last_d    = req_last[sel];
          tx_data_d = req_data[{sel, 3'b000} +: 8];
          tx_send_d = 1'b1;
          req_ack_d = onehot(sel);
          cnt_d     = '0;
        end else if (locked && !halt && LOCK_TIMEOUT != 0) begin
          if (tmo_cnt == TMO_LAST) begin
            locked_d      = 1'b0;
            grant_d       = '0;
            ptr_d         = wrap_add(owner, 1);
            timeout_err_d = 1'b1;
            cnt_d         = '0;
          end else begin
            cnt_d = tmo_cnt + CNT_W'(1);
          end
        end
      end
      ISSUE: state_d = WAIT_START;
      WAIT_START: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          if (last_q) begin
            locked_d = 1'b0;
            grant_d  = '0;
            ptr_d    = wrap_add(owner, 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      last_q      <= 1'b0;
      locked      <= 1'b0;
      tmo_cnt     <= '0;
      grant       <= '0;
      tx_data     <= '0;
      tx_send     <= 1'b0;
      req_ack     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      owner       <= owner_d;
      last_q      <= last_d;
      locked      <= locked_d;
      tmo_cnt     <= cnt_d;
      grant       <= grant_d;
      tx_data     <= tx_data_d;
      tx_send     <= tx_send_d;
      req_ack     <= req_ack_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule
